// File: rtl/fft_frame_sequencer.sv
// Double-buffers signed audio samples into fixed-length frames and streams each
// completed frame to the FFT core over AXI-Stream with tlast and back-pressure.
module fft_frame_sequencer #(
  parameter int unsigned SAMPLE_WIDTH = 8,
  parameter int unsigned FRAME_LEN    = 1024,
  parameter int unsigned COUNT_WIDTH  = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    enable_in,
  input  logic                    sample_valid_in,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  output logic [31:0]             m_tdata,
  output logic                    m_tvalid,
  output logic                    m_tlast,
  input  logic                    m_tready,
  output logic                    frame_start_out,
  output logic                    frame_done_out,
  output logic                    busy_out,
  output logic [COUNT_WIDTH-1:0]  frames_out,
  output logic [COUNT_WIDTH-1:0]  overruns_out
);

  localparam int unsigned IdxW = $clog2(FRAME_LEN);
  localparam int unsigned PadW = 16 - SAMPLE_WIDTH;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(FRAME_LEN - 1);

  typedef enum logic {StIdle, StStream} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              bank_full_q, bank_full_d;
  logic                    wr_bank_q, wr_bank_d;
  logic                    rd_bank_q, rd_bank_d;
  logic [IdxW-1:0]         wr_idx_q, wr_idx_d;
  logic [IdxW-1:0]         rd_idx_q, rd_idx_d;
  logic [COUNT_WIDTH-1:0]  frames_q, frames_d;
  logic [COUNT_WIDTH-1:0]  overruns_q, overruns_d;
  logic                    start_q, start_d;
  logic                    done_q, done_d;
  logic [SAMPLE_WIDTH-1:0] mem_q [2*FRAME_LEN];

  logic wr_store;
  logic wr_wrap;
  logic rd_last;
  logic rd_finish;

  // A bank being filled is never full, so set and clear always hit different banks.
  assign wr_store  = sample_valid_in && enable_in && !bank_full_q[wr_bank_q];
  assign wr_wrap   = wr_store && (wr_idx_q == LastIdx);
  assign rd_last   = (rd_idx_q == LastIdx);
  assign rd_finish = (state_q == StStream) && m_tready && rd_last;

  always_ff @(posedge clk_in) begin
    if (wr_store) begin
      mem_q[{wr_bank_q, wr_idx_q}] <= sample_in;
    end
  end

  always_comb begin
    wr_idx_d   = wr_idx_q;
    wr_bank_d  = wr_bank_q;
    overruns_d = overruns_q;
    if (!enable_in) begin
      wr_idx_d = '0;
    end else if (sample_valid_in) begin
      if (bank_full_q[wr_bank_q]) begin
        if (overruns_q != '1) overruns_d = overruns_q + 1'b1;
      end else if (wr_idx_q == LastIdx) begin
        wr_idx_d  = '0;
        wr_bank_d = ~wr_bank_q;
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    bank_full_d = bank_full_q;
    if (wr_wrap)   bank_full_d[wr_bank_q] = 1'b1;
    if (rd_finish) bank_full_d[rd_bank_q] = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    rd_idx_d  = rd_idx_q;
    rd_bank_d = rd_bank_q;
    frames_d  = frames_q;
    start_d   = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bank_full_q[rd_bank_q]) begin
          state_d  = StStream;
          rd_idx_d = '0;
          start_d  = 1'b1;
        end
      end
      StStream: begin
        if (m_tready) begin
          if (rd_last) begin
            state_d   = StIdle;
            rd_bank_d = ~rd_bank_q;
            frames_d  = frames_q + 1'b1;
            done_d    = 1'b1;
          end else begin
            rd_idx_d = rd_idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= StIdle;
      bank_full_q <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      frames_q    <= '0;
      overruns_q  <= '0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_full_q <= bank_full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      frames_q    <= frames_d;
      overruns_q  <= overruns_d;
      start_q     <= start_d;
      done_q      <= done_d;
    end
  end

  // Outputs decode registered state only, so valid never depends on tready.
  always_comb begin
    m_tvalid = (state_q == StStream);
    m_tlast  = m_tvalid && rd_last;
    m_tdata  = '0;
    if (m_tvalid) begin
      m_tdata = {16'h0000, mem_q[{rd_bank_q, rd_idx_q}], {PadW{1'b0}}};
    end
  end

  assign busy_out        = m_tvalid;
  assign frame_start_out = start_q;
  assign frame_done_out  = done_q;
  assign frames_out      = frames_q;
  assign overruns_out    = overruns_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Scoreboard bench for fft_frame_sequencer with FRAME_LEN = 8: stimulus pushes the
// expected beats, a negedge monitor pops and compares every AXI-Stream handshake.
module tb_fft_frame_sequencer;

  localparam int unsigned FrameLen = 8;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        enable_in = 1'b1;
  logic        sample_valid_in = 1'b0;
  logic [7:0]  sample_in = 8'h00;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready;
  logic        frame_start_out;
  logic        frame_done_out;
  logic        busy_out;
  logic [15:0] frames_out;
  logic [15:0] overruns_out;

  logic rdy_toggle = 1'b0;
  logic rdy_val    = 1'b1;
  logic tog        = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [32:0] sb[$];

  assign m_tready = rdy_toggle ? tog : rdy_val;

  fft_frame_sequencer #(
    .SAMPLE_WIDTH(8),
    .FRAME_LEN   (FrameLen),
    .COUNT_WIDTH (16)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .enable_in      (enable_in),
    .sample_valid_in(sample_valid_in),
    .sample_in      (sample_in),
    .m_tdata        (m_tdata),
    .m_tvalid       (m_tvalid),
    .m_tlast        (m_tlast),
    .m_tready       (m_tready),
    .frame_start_out(frame_start_out),
    .frame_done_out (frame_done_out),
    .busy_out       (busy_out),
    .frames_out     (frames_out),
    .overruns_out   (overruns_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    forever begin
      @(posedge clk_in);
      #1 tog = ~tog;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  // Monitor: handshake ordering, AXI stability while stalled, and the done pulse.
  logic        prev_stall = 1'b0;
  logic        prev_last_hs = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;

  always @(negedge clk_in) begin
    logic [32:0] exp;
    if (!rst_in) begin
      prev_stall   = 1'b0;
      prev_last_hs = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", {31'd0, m_tvalid}, 32'd1);
        check("hold_data", m_tdata, prev_data);
        check("hold_last", {31'd0, m_tlast}, {31'd0, prev_last});
      end
      check("done_pulse", {31'd0, frame_done_out}, {31'd0, prev_last_hs});
      if (m_tvalid && m_tready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got=%h want=none", m_tdata);
        end else begin
          exp = sb.pop_front();
          check("beat_data", m_tdata, exp[31:0]);
          check("beat_last", {31'd0, m_tlast}, {31'd0, exp[32]});
        end
      end
      prev_stall   = m_tvalid && !m_tready;
      prev_data    = m_tdata;
      prev_last    = m_tlast;
      prev_last_hs = m_tvalid && m_tready && m_tlast;
    end
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] s, input int gap);
    @(posedge clk_in);
    #1 sample_valid_in = 1'b1;
    sample_in = s;
    @(posedge clk_in);
    #1 sample_valid_in = 1'b0;
    cycles(gap);
  endtask

  task automatic expect_beat(input logic [7:0] s, input logic last);
    sb.push_back({last, 16'h0000, s, 8'h00});
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      cycles(1);
      n++;
    end
    check(name, sb.size(), 0);
    cycles(3);
  endtask

  initial begin
    // Reset behaviour
    cycles(3);
    check("rst_valid", {31'd0, m_tvalid}, 32'd0);
    #1 rst_in = 1'b1;
    cycles(1);
    check("rst_tdata", m_tdata, 32'd0);
    check("rst_flags", {27'd0, m_tvalid, m_tlast, frame_start_out, frame_done_out, busy_out},
          32'd0);
    check("rst_frames", {16'd0, frames_out}, 32'd0);
    check("rst_overruns", {16'd0, overruns_out}, 32'd0);
    begin
      int busy_seen = 0;
      for (int i = 0; i < 100; i++) begin
        cycles(1);
        if (busy_out) busy_seen++;
      end
      check("idle_busy", busy_seen, 0);
    end

    // Single frame, ready held high
    for (int i = 1; i <= 7; i++) begin
      expect_beat(8'(i), 1'b0);
      send(8'(i), 2);
    end
    expect_beat(8'h08, 1'b1);
    send(8'h08, 0);
    check("start_early", {31'd0, frame_start_out}, 32'd0);
    cycles(1);
    check("start_pulse", {31'd0, frame_start_out}, 32'd1);
    check("start_busy", {31'd0, busy_out}, 32'd1);
    drain("single_drain", 40);
    check("single_frames", {16'd0, frames_out}, 32'd1);
    check("single_busy", {31'd0, busy_out}, 32'd0);

    // Back-pressure: ready toggles every cycle
    rdy_toggle = 1'b1;
    for (int i = 0; i < 8; i++) begin
      expect_beat(8'h80 + 8'(i * 9), i == 7);
      send(8'h80 + 8'(i * 9), 2);
    end
    drain("bp_drain", 60);
    rdy_toggle = 1'b0;
    check("bp_frames", {16'd0, frames_out}, 32'd2);

    // Overrun: both banks fill, four samples dropped
    rdy_val = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i < 16) expect_beat(8'h20 + 8'(i), (i == 7) || (i == 15));
      send(8'h20 + 8'(i), 1);
    end
    cycles(2);
    check("ovr_count", {16'd0, overruns_out}, 32'd4);
    check("ovr_queued", sb.size(), 16);
    rdy_val = 1'b1;
    drain("ovr_drain", 80);
    check("ovr_frames", {16'd0, frames_out}, 32'd4);

    // Disable mid-frame discards the partial frame
    for (int i = 0; i < 5; i++) send(8'hA0 + 8'(i), 1);
    enable_in = 1'b0;
    cycles(1);
    enable_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      expect_beat(8'hC0 + 8'(i), i == 7);
      send(8'hC0 + 8'(i), 1);
    end
    drain("dis_drain", 40);
    check("dis_frames", {16'd0, frames_out}, 32'd5);

    // Reset mid-stream abandons the frame at handshake 3
    rdy_val = 1'b0;
    for (int i = 0; i < 8; i++) begin
      expect_beat(8'h50 + 8'(i), i == 7);
      send(8'h50 + 8'(i), 0);
    end
    begin
      int n = 0;
      while (!m_tvalid && n < 20) begin
        cycles(1);
        n++;
      end
      check("mid_wait_valid", {31'd0, m_tvalid}, 32'd1);
    end
    rdy_val = 1'b1;
    cycles(2);
    rst_in = 1'b0;
    #1;
    check("mid_valid_drop", {31'd0, m_tvalid}, 32'd0);
    check("mid_last_low", {31'd0, m_tlast}, 32'd0);
    check("mid_beats_left", sb.size(), 6);
    sb.delete();
    cycles(2);
    rst_in = 1'b1;
    cycles(1);
    check("mid_frames", {16'd0, frames_out}, 32'd0);
    check("mid_overruns", {16'd0, overruns_out}, 32'd0);
    cycles(30);
    check("mid_no_stale", {31'd0, busy_out}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
